// File: rtl/led_sequencer_if.sv
// rtl/led_sequencer_if.sv - run/stop/mode requests and LED pattern outputs of the LED sequencer
interface led_sequencer_if #(
  parameter int NLED = 8
);
  logic            start;
  logic            stop;
  logic [1:0]      mode;
  logic [NLED-1:0] LEDG;
  logic            tick;
  logic            busy;

  modport master (
    output start, stop, mode,
    input  LEDG, tick, busy
  );

  modport slave (
    input  start, stop, mode,
    output LEDG, tick, busy
  );
endinterface

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - IDLE/RUN/HOLD LED pattern sequencer stepping every DIV clocks
// Optional: define LED_SEQ_BOUNCE_EN for ping-pong chase instead of rotate-left.
module led_sequencer #(
  parameter int DIV  = 50000000,
  parameter int NLED = 8
) (
  input  logic             CLOCK_50,
  input  logic             KEY,
  led_sequencer_if.slave   bus
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [NLED-1:0] pat_q, pat_d;
  logic            tick_q, tick_d;
  logic [NLED-1:0] load_pat;
  logic [NLED-1:0] step_pat;
  logic            wrap;

`ifdef LED_SEQ_BOUNCE_EN
  logic            dir_up_q, dir_up_d;
  logic            step_dir_up;
`endif

  assign wrap = (presc_q == PRESC_MAX);

  always_comb begin
    load_pat = '0;
    case (bus.mode)
      2'b00:   load_pat = '0;
      2'b01:   load_pat = '1;
      2'b10:   load_pat = NLED'(1);
      default: load_pat = '1;
    endcase
  end

  // Pattern for the next wrap edge, chosen from the mode sampled at that edge.
  always_comb begin
    step_pat = '0;
`ifdef LED_SEQ_BOUNCE_EN
    step_dir_up = dir_up_q;
`endif
    case (bus.mode)
      2'b00: step_pat = '0;
      2'b01: step_pat = ~pat_q;
      2'b10: begin
        if (pat_q == '0) begin
          step_pat = NLED'(1);
        end else begin
`ifdef LED_SEQ_BOUNCE_EN
          if (dir_up_q) begin
            if (pat_q[NLED-1]) begin
              step_pat    = pat_q >> 1;
              step_dir_up = 1'b0;
            end else begin
              step_pat = pat_q << 1;
            end
          end else begin
            if (pat_q[0]) begin
              step_pat    = pat_q << 1;
              step_dir_up = 1'b1;
            end else begin
              step_pat = pat_q >> 1;
            end
          end
`else
          step_pat = {pat_q[NLED-2:0], pat_q[NLED-1]};
`endif
        end
      end
      default: step_pat = '1;
    endcase
  end

  // Stop has priority over start in every state.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    pat_d   = pat_q;
    tick_d  = 1'b0;
`ifdef LED_SEQ_BOUNCE_EN
    dir_up_d = dir_up_q;
`endif
    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        if (bus.start && !bus.stop) begin
          state_d = S_RUN;
          pat_d   = load_pat;
`ifdef LED_SEQ_BOUNCE_EN
          dir_up_d = 1'b1;
`endif
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          state_d = S_HOLD;
        end else if (wrap) begin
          presc_d = '0;
          tick_d  = 1'b1;
          pat_d   = step_pat;
`ifdef LED_SEQ_BOUNCE_EN
          dir_up_d = step_dir_up;
`endif
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      S_HOLD: begin
        if (bus.stop) begin
          state_d = S_IDLE;
          pat_d   = '0;
          presc_d = '0;
        end else if (bus.start) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
        presc_d = '0;
        pat_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge KEY) begin
    if (KEY) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      pat_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      pat_q   <= pat_d;
      tick_q  <= tick_d;
    end
  end

`ifdef LED_SEQ_BOUNCE_EN
  always_ff @(posedge CLOCK_50 or posedge KEY) begin
    if (KEY) begin
      dir_up_q <= 1'b1;
    end else begin
      dir_up_q <= dir_up_d;
    end
  end
`endif

  assign bus.LEDG = pat_q;
  assign bus.tick = tick_q;
  assign bus.busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - scoreboard bench for led_sequencer with DIV=4, NLED=4
module tb_led_sequencer;
  localparam int DIV  = 4;
  localparam int NLED = 4;

  logic CLOCK_50 = 1'b0;
  logic KEY      = 1'b1;

  led_sequencer_if #(.NLED(NLED)) bus ();

  led_sequencer #(.DIV(DIV), .NLED(NLED)) dut (
    .CLOCK_50 (CLOCK_50),
    .KEY      (KEY),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int              cyc;
    logic [NLED-1:0] led;
  } exp_t;

  exp_t            exp_q[$];
  logic [NLED-1:0] seen_q[$];
  int              seen_cyc[$];
  int              n_checks = 0;
  int              n_fail   = 0;
  int              cyc      = 0;

  // Reference model: run-cycle counting and pattern rules, state 0=IDLE 1=RUN 2=HOLD.
  int              m_state = 0;
  int              m_run_cycles = 0;
  logic [NLED-1:0] m_pat = '0;
  bit              m_up = 1'b1;

  function automatic logic [NLED-1:0] all_ones();
    return {NLED{1'b1}};
  endfunction

  always @(posedge CLOCK_50 or posedge KEY) begin
    if (KEY) begin
      m_state      = 0;
      m_run_cycles = 0;
      m_pat        = '0;
      m_up         = 1'b1;
      exp_q.delete();
    end else begin
      cyc = cyc + 1;
      case (m_state)
        0: if (bus.start && !bus.stop) begin
          m_state      = 1;
          m_run_cycles = 0;
          m_up         = 1'b1;
          case (bus.mode)
            2'b00: m_pat = '0;
            2'b10: m_pat = 1;
            default: m_pat = all_ones();
          endcase
        end
        1: if (bus.stop) begin
          m_state = 2;
        end else begin
          m_run_cycles = m_run_cycles + 1;
          if (m_run_cycles % DIV == 0) begin
            case (bus.mode)
              2'b00: m_pat = '0;
              2'b01: m_pat = ~m_pat;
              2'b11: m_pat = all_ones();
              default: begin
                if (m_pat == 0) m_pat = 1;
`ifdef LED_SEQ_BOUNCE_EN
                else if (m_up && m_pat[NLED-1]) begin m_pat = m_pat / 2; m_up = 1'b0; end
                else if (!m_up && m_pat[0]) begin m_pat = m_pat * 2; m_up = 1'b1; end
                else if (m_up) m_pat = m_pat * 2;
                else m_pat = m_pat / 2;
`else
                else m_pat = (m_pat * 2) | (m_pat >> (NLED - 1));
`endif
              end
            endcase
            exp_q.push_back('{cyc, m_pat});
          end
        end
        default: if (bus.stop) begin
          m_state = 0;
          m_pat   = '0;
        end else if (bus.start) begin
          m_state = 1;
        end
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge CLOCK_50);
      if (!KEY) begin
        check("ledg_vs_model", 32'(bus.LEDG), 32'(m_pat));
        check("busy_vs_model", 32'(bus.busy), 32'(m_state != 0));
        if (bus.tick) begin
          seen_q.push_back(bus.LEDG);
          seen_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            check("tick_unexpected", 32'(bus.tick), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("tick_cycle", 32'(cyc), 32'(e.cyc));
            check("tick_ledg", 32'(bus.LEDG), 32'(e.led));
          end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          e = exp_q.pop_front();
          check("tick_missing", 32'(bus.tick), 32'd1);
        end
      end
    end
  endtask

  task automatic pulse(input logic s, input logic t);
    @(negedge CLOCK_50);
    bus.start = s;
    bus.stop  = t;
    @(negedge CLOCK_50);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    int got;
    got = 0;
    for (int i = 0; i < 200 && got < n; i++) begin
      @(negedge CLOCK_50);
      if (bus.tick) got++;
    end
    check("wait_ticks_bound", 32'(got), 32'(n));
    #1;
  endtask

  logic [NLED-1:0] chase_exp[$];
  logic [NLED-1:0] frozen;
  int              base;
  int              gap;

  initial begin
`ifdef LED_SEQ_BOUNCE_EN
    chase_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
`else
    chase_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.mode  = 2'b00;
    fork monitor(); join_none

    repeat (3) @(negedge CLOCK_50);
    #1;
    check("reset_ledg", 32'(bus.LEDG), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_tick", 32'(bus.tick), 32'd0);
    @(negedge CLOCK_50);
    KEY = 1'b0;

    pulse(1'b1, 1'b1);
    check("idle_start_stop_busy", 32'(bus.busy), 32'd0);

    bus.mode = 2'b01;
    seen_q.delete();
    seen_cyc.delete();
    pulse(1'b1, 1'b0);
    check("blink_load", 32'(bus.LEDG), 32'hF);
    wait_ticks(2);
    check("blink_step1", 32'(seen_q[0]), 32'h0);
    check("blink_step2", 32'(seen_q[1]), 32'hF);
    check("blink_spacing", 32'(seen_cyc[1] - seen_cyc[0]), 32'(DIV));

    wait_ticks(1);
    bus.mode = 2'b11;
    @(negedge CLOCK_50);
    check("mode_change_no_glitch", 32'(bus.LEDG), 32'h0);
    wait_ticks(1);
    check("mode_change_applied", 32'(bus.LEDG), 32'hF);

    bus.mode = 2'b01;
    wait_ticks(1);
    repeat (2) @(negedge CLOCK_50);
    bus.stop = 1'b1;
    @(negedge CLOCK_50);
    bus.stop = 1'b0;
    frozen = bus.LEDG;
    base = seen_q.size();
    repeat (20) @(negedge CLOCK_50);
    check("hold_frozen", 32'(bus.LEDG), 32'(frozen));
    check("hold_no_tick", 32'(seen_q.size() - base), 32'd0);
    check("hold_busy", 32'(bus.busy), 32'd1);
    pulse(1'b1, 1'b0);
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK_50);
      gap++;
      if (bus.tick) break;
    end
    check("resume_tick_gap", 32'(gap), 32'd2);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    check("hold_to_idle_ledg", 32'(bus.LEDG), 32'd0);
    check("hold_to_idle_busy", 32'(bus.busy), 32'd0);

    bus.mode = 2'b10;
    seen_q.delete();
    seen_cyc.delete();
    pulse(1'b1, 1'b0);
    check("chase_load", 32'(bus.LEDG), 32'h1);
    wait_ticks(chase_exp.size());
    foreach (chase_exp[i]) check($sformatf("chase_step%0d", i), 32'(seen_q[i]), 32'(chase_exp[i]));

    pulse(1'b1, 1'b1);
    check("run_start_stop_busy", 32'(bus.busy), 32'd1);
    base = seen_q.size();
    repeat (10) @(negedge CLOCK_50);
    check("run_start_stop_holds", 32'(seen_q.size() - base), 32'd0);
    pulse(1'b0, 1'b1);
    check("run_start_stop_idle", 32'(bus.busy), 32'd0);

    bus.mode = 2'b01;
    pulse(1'b1, 1'b0);
    wait_ticks(1);
    #1 KEY = 1'b1;
    #1;
    check("async_reset_ledg", 32'(bus.LEDG), 32'd0);
    check("async_reset_busy", 32'(bus.busy), 32'd0);
    check("async_reset_tick", 32'(bus.tick), 32'd0);
    repeat (2) @(negedge CLOCK_50);
    KEY = 1'b0;
    repeat (8) @(negedge CLOCK_50);
    check("reset_needs_start", 32'(bus.busy), 32'd0);

    bus.mode = 2'b10;
    pulse(1'b1, 1'b0);
    repeat (3) @(negedge CLOCK_50);
    pulse(1'b0, 1'b1);
    #2 KEY = 1'b1;
    #1;
    check("hold_reset_ledg", 32'(bus.LEDG), 32'd0);
    check("hold_reset_busy", 32'(bus.busy), 32'd0);
    @(negedge CLOCK_50);
    KEY = 1'b0;

    for (int i = 0; i < 600; i++) begin
      @(negedge CLOCK_50);
      bus.start = ($urandom_range(0, 5) == 0);
      bus.stop  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) bus.mode = 2'($urandom_range(0, 3));
    end
    bus.start = 1'b0;
    bus.stop  = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    bus.stop  = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
- REQ-001 SHALL have parameter DIV, default 50000000: clock cycles per pattern step; legal range 2..2^26.
- REQ-002 SHALL have parameter NLED, default 8: LED count; legal range 2..32.
- REQ-003 SHALL have port CLOCK_50, input, 1 bit: the single clock; all flops on its rising edge.
- REQ-004 SHALL have port KEY, input, 1 bit: reset, asynchronous, active-high.
- REQ-005 SHALL have port start, input, 1 bit: level-sampled run request.
- REQ-006 SHALL have port stop, input, 1 bit: level-sampled hold/clear request.
- REQ-007 SHALL have port mode, input, 2 bits: pattern select; 00 off, 01 blink, 10 chase, 11 solid.
- REQ-008 SHALL have port LEDG, output, NLED bits: registered pattern register pat.
- REQ-009 SHALL have port tick, output, 1 bit: registered one-cycle pulse per completed step.
- REQ-010 SHALL have port busy, output, 1 bit: high in RUN and HOLD.

Function
- REQ-011 SHALL implement an FSM with states IDLE, RUN and HOLD.
- REQ-012 SHALL go IDLE->RUN on start=1 with stop=0; in the same edge it SHALL load pat from mode: 00->0, 01->all ones, 10->1, 11->all ones.
- REQ-013 SHALL go RUN->HOLD on stop=1, freezing pat and the prescaler.
- REQ-014 SHALL go HOLD->RUN on start=1 with stop=0, resuming with pat and prescaler unchanged.
- REQ-015 SHALL go HOLD->IDLE on stop=1, clearing pat to 0.
- REQ-016 SHALL let stop win when start and stop are both 1; start in RUN and stop in IDLE SHALL be ignored.
- REQ-017 SHALL use a prescaler of ceil(log2(DIV)) bits that increments only in RUN, wraps from DIV-1 to 0, and is cleared in IDLE.
- REQ-018 SHALL drive tick=1 for exactly one cycle, on the cycle after the edge where the prescaler wraps; the first tick after IDLE->RUN SHALL be asserted DIV cycles after the transition edge.
- REQ-019 SHALL update pat on each wrap edge from the mode sampled at that edge: 00->0; 01->~pat; 10->0 becomes 1, otherwise step per REQ-024/025; 11->all ones.
- REQ-020 SHALL let a mode change mid-RUN take effect only at the next wrap; no glitch or reload SHALL occur between wraps.
- REQ-021 SHALL keep LEDG equal to pat with no combinational path from inputs to outputs.

Reset
- REQ-022 SHALL, while KEY=1 and independent of the clock, force state=IDLE, prescaler=0, pat=0, tick=0 and busy=0.
- REQ-023 SHALL, on KEY assertion mid-RUN or mid-HOLD, abandon the operation with no residual tick; after release, operation SHALL require a fresh start.

Configuration
- REQ-024 SHALL, without macro LED_SEQ_BOUNCE_EN, step chase as rotate-left by 1 with bit NLED-1 wrapping to bit 0.
- REQ-025 SHALL, with LED_SEQ_BOUNCE_EN defined, step chase as ping-pong: add a direction flop (reset: up), reverse at bit NLED-1 and at bit 0, and set direction to up on each IDLE->RUN.

Verification
With DIV=4 and NLED=4:
- REQ-026 SHALL check reset: KEY=1 mid-RUN -> LEDG=0000, busy=0 and tick=0 immediately, without a clock edge.
- REQ-027 SHALL check blink: start with mode=01 -> LEDG=1111, then 0000, 1111 on successive ticks, with tick pulses exactly 4 cycles apart.
- REQ-028 SHALL check chase without LED_SEQ_BOUNCE_EN: mode=10 -> LEDG 0001, 0010, 0100, 1000, 0001.
- REQ-029 SHALL check chase with LED_SEQ_BOUNCE_EN: mode=10 -> LEDG 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
- REQ-030 SHALL check hold: stop 2 cycles after a tick -> LEDG frozen and no tick for 20 cycles; start -> next tick exactly 2 cycles later; stop twice -> IDLE with LEDG=0000.
- REQ-031 SHALL check simultaneous requests: start=stop=1 in IDLE -> remains IDLE; start=stop=1 in RUN -> HOLD; mode changed from 01 to 11 between ticks -> LEDG unchanged until the next tick, then 1111.
